// File: rtl/cdl_ctrl_pkg.sv
// Shared types and default parameters for the coarse delay-line controller.
package cdl_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILTER,
        ST_SETTLE,
        ST_LOCKED
    } state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    localparam int DEF_N_CELLS    = 16;
    localparam int DEF_FILT_LEN   = 4;
    localparam int DEF_SETTLE_CYC = 3;
    localparam int DEF_LOCK_REV   = 3;
    localparam int DEF_INIT_CODE  = 0;

endpackage

// File: rtl/cdl_ctrl_therm_enc.sv
// Combinational binary-to-thermometer encoder: t[i]=1 iff i<code, tb=~t.
module therm_enc #(
    parameter int N_CELLS = 16,
    parameter int CW      = $clog2(N_CELLS + 1)
) (
    input  logic [CW-1:0]      code,
    output logic [N_CELLS-1:0] t,
    output logic [N_CELLS-1:0] tb
);

    always_comb begin
        t = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            t[i] = (i < int'(code));
        end
    end

    assign tb = ~t;

endmodule

// File: rtl/cdl_ctrl.sv
// Coarse delay-line controller: filters phase-detector votes into +/-1 code
// steps, waits for the line to settle, and declares lock on repeated reversals.
module cdl_ctrl
    import cdl_ctrl_pkg::*;
#(
    parameter int N_CELLS    = DEF_N_CELLS,
    parameter int FILT_LEN   = DEF_FILT_LEN,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int LOCK_REV   = DEF_LOCK_REV,
    parameter int INIT_CODE  = DEF_INIT_CODE,
    localparam int CW        = $clog2(N_CELLS + 1)
) (
    input  logic               clk_ref,
    input  logic               rst_n,
    input  logic               en,
    input  logic               up,
    input  logic               dn,
    output logic [N_CELLS-1:0] T,
    output logic [N_CELLS-1:0] Tb,
    output logic [CW-1:0]      code,
    output logic               locked,
    output logic               sat_hi,
    output logic               sat_lo
);

    localparam int VW = $clog2(2 * FILT_LEN + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int RW = $clog2(LOCK_REV + 1);
    localparam logic [N_CELLS-1:0] T_INIT = ~({N_CELLS{1'b1}} << INIT_CODE);

    state_e            state_q, state_d;
    logic [CW-1:0]     code_q, code_d;
    logic [VW-1:0]     vote_cnt_q, vote_cnt_d;
    dir_e              vote_dir_q, vote_dir_d;
    dir_e              last_dir_q, last_dir_d;
    logic              have_last_q, have_last_d;
    logic [RW-1:0]     rev_cnt_q, rev_cnt_d;
    logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
    logic              locked_q, locked_d;
    logic              sat_hi_q, sat_hi_d;
    logic              sat_lo_q, sat_lo_d;
    logic [N_CELLS-1:0] t_q, tb_q, t_enc, tb_enc;

    logic          vote_vld;
    dir_e          vote_is;
    logic [VW-1:0] cnt_nxt;
    dir_e          dir_nxt;
    logic [VW-1:0] thresh;
    logic          blocked;

    always_comb begin
        vote_vld = up ^ dn;
        vote_is  = dn ? DIR_DN : DIR_UP;
        dir_nxt  = vote_dir_q;
        if (!vote_vld) begin
            cnt_nxt = '0;
        end else if (vote_cnt_q != '0 && vote_dir_q == vote_is) begin
            cnt_nxt = vote_cnt_q + 1'b1;
        end else begin
            cnt_nxt = VW'(1);
            dir_nxt = vote_is;
        end
        thresh  = (state_q == ST_LOCKED) ? VW'(2 * FILT_LEN) : VW'(FILT_LEN);
        blocked = (vote_is == DIR_UP) ? (code_q == CW'(N_CELLS)) : (code_q == '0);
    end

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        vote_cnt_d   = vote_cnt_q;
        vote_dir_d   = vote_dir_q;
        last_dir_d   = last_dir_q;
        have_last_d  = have_last_q;
        rev_cnt_d    = rev_cnt_q;
        settle_cnt_d = settle_cnt_q;
        sat_hi_d     = sat_hi_q;
        sat_lo_d     = sat_lo_q;

        if (!en) begin
            state_d      = ST_IDLE;
            vote_cnt_d   = '0;
            rev_cnt_d    = '0;
            settle_cnt_d = '0;
            have_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_FILTER;
                    vote_cnt_d   = '0;
                    rev_cnt_d    = '0;
                    settle_cnt_d = '0;
                    have_last_d  = 1'b0;
                    sat_hi_d     = 1'b0;
                    sat_lo_d     = 1'b0;
                end
                ST_FILTER, ST_LOCKED: begin
                    vote_cnt_d = cnt_nxt;
                    vote_dir_d = dir_nxt;
                    if (cnt_nxt == thresh) begin
                        vote_cnt_d = '0;
                        if (state_q == ST_LOCKED) rev_cnt_d = '0;
                        if (blocked) begin
                            // A blocked step is not a step: no settle, no reversal update.
                            if (vote_is == DIR_UP) sat_hi_d = 1'b1;
                            else                   sat_lo_d = 1'b1;
                            state_d = ST_FILTER;
                        end else begin
                            code_d       = (vote_is == DIR_UP) ? code_q + 1'b1 : code_q - 1'b1;
                            state_d      = ST_SETTLE;
                            settle_cnt_d = '0;
                            if (state_q == ST_FILTER && have_last_q) begin
                                if (last_dir_q != vote_is) begin
                                    if (rev_cnt_q != RW'(LOCK_REV)) rev_cnt_d = rev_cnt_q + 1'b1;
                                end else begin
                                    rev_cnt_d = '0;
                                end
                            end
                            have_last_d = 1'b1;
                            last_dir_d  = vote_is;
                        end
                    end
                end
                ST_SETTLE: begin
                    vote_cnt_d = '0;
                    if (settle_cnt_q == SW'(SETTLE_CYC - 1)) begin
                        settle_cnt_d = '0;
                        state_d      = (rev_cnt_q >= RW'(LOCK_REV)) ? ST_LOCKED : ST_FILTER;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    therm_enc #(.N_CELLS(N_CELLS), .CW(CW)) u_therm (
        .code (code_d),
        .t    (t_enc),
        .tb   (tb_enc)
    );

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            code_q       <= CW'(INIT_CODE);
            vote_cnt_q   <= '0;
            vote_dir_q   <= DIR_UP;
            last_dir_q   <= DIR_UP;
            have_last_q  <= 1'b0;
            rev_cnt_q    <= '0;
            settle_cnt_q <= '0;
            locked_q     <= 1'b0;
            sat_hi_q     <= 1'b0;
            sat_lo_q     <= 1'b0;
            t_q          <= T_INIT;
            tb_q         <= ~T_INIT;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            vote_cnt_q   <= vote_cnt_d;
            vote_dir_q   <= vote_dir_d;
            last_dir_q   <= last_dir_d;
            have_last_q  <= have_last_d;
            rev_cnt_q    <= rev_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            locked_q     <= locked_d;
            sat_hi_q     <= sat_hi_d;
            sat_lo_q     <= sat_lo_d;
            t_q          <= t_enc;
            tb_q         <= tb_enc;
        end
    end

    assign T      = t_q;
    assign Tb     = tb_q;
    assign code   = code_q;
    assign locked = locked_q;
    assign sat_hi = sat_hi_q;
    assign sat_lo = sat_lo_q;

endmodule

// File: tb/tb_cdl_ctrl.sv
// Directed bench for cdl_ctrl with default parameters (16 cells, filter 4, settle 3).
module tb_cdl_ctrl;

    logic        clk_ref = 1'b0;
    logic        rst_n, en, up, dn;
    logic [15:0] T, Tb;
    logic [4:0]  code;
    logic        locked, sat_hi, sat_lo;

    int checks = 0;
    int errors = 0;

    cdl_ctrl dut (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .en      (en),
        .up      (up),
        .dn      (dn),
        .T       (T),
        .Tb      (Tb),
        .code    (code),
        .locked  (locked),
        .sat_hi  (sat_hi),
        .sat_lo  (sat_lo)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic vote(input logic u, input logic d, input int n);
        up = u;
        dn = d;
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b0; dn = 1'b0;
        #12;
        chk("rst_T", T, 16'h0000);
        chk("rst_Tb", Tb, 16'hFFFF);
        chk("rst_code", code, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sat", {sat_hi, sat_lo}, 0);

        // Filtering: 4 UP votes step 0->1; settle swallows the next 3.
        rst_n = 1'b1;
        tick();
        en = 1'b1;
        vote(0, 0, 1);
        vote(1, 0, 3);
        chk("filt_no_step_3", code, 0);
        vote(1, 0, 1);
        chk("filt_step_code", code, 1);
        chk("filt_step_T", T, 16'h0001);
        chk("filt_step_Tb", Tb, 16'hFFFE);
        vote(1, 0, 3);
        chk("settle_ignored", code, 1);
        vote(1, 0, 3);
        chk("post_settle_3", code, 1);
        vote(1, 0, 1);
        chk("post_settle_step", code, 2);
        vote(0, 0, 3);

        // Noise patterns.
        vote(1, 0, 3); vote(0, 1, 1); vote(1, 0, 3);
        chk("noise_dn_break", code, 2);
        vote(1, 1, 1); vote(1, 0, 3);
        chk("noise_both_clear", code, 2);
        vote(1, 0, 1);
        chk("noise_then_step", code, 3);
        chk("noise_then_T", T, 16'h0007);
        vote(0, 0, 3);

        // Climb to 8.
        for (int s = 0; s < 5; s++) begin
            vote(1, 0, 4);
            vote(0, 0, 3);
        end
        chk("climb_code", code, 8);
        chk("climb_T", T, 16'h00FF);

        // Lock: alternating bursts, 3 reversals.
        vote(1, 0, 4); chk("lock_s1", code, 9); vote(0, 0, 3);
        vote(0, 1, 4); chk("lock_s2", code, 8); vote(0, 0, 3);
        chk("lock_not_yet", locked, 0);
        vote(1, 0, 4); chk("lock_s3", code, 9); vote(0, 0, 3);
        vote(0, 1, 4); chk("lock_s4", code, 8);
        chk("lock_s4_unlocked", locked, 0);
        vote(0, 0, 2);
        chk("lock_settle_2", locked, 0);
        vote(0, 0, 1);
        chk("locked_set", locked, 1);

        // Frozen while locked; 8 DN votes unlock and step.
        vote(1, 0, 7);
        chk("frozen_code", code, 8);
        chk("frozen_locked", locked, 1);
        vote(0, 1, 7);
        chk("frozen_dn7", code, 8);
        vote(0, 1, 1);
        chk("unlock_code", code, 7);
        chk("unlock_locked", locked, 0);
        chk("unlock_T", T, 16'h007F);

        // Reset mid-settle aborts at once.
        vote(0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_code", code, 0);
        chk("abort_T", T, 16'h0000);
        chk("abort_Tb", Tb, 16'hFFFF);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        vote(1, 0, 5);
        chk("wait_en", code, 0);

        // Saturation high.
        en = 1'b1;
        vote(0, 0, 1);
        for (int s = 0; s < 16; s++) begin
            vote(1, 0, 4);
            vote(0, 0, 3);
        end
        chk("top_code", code, 16);
        chk("top_T", T, 16'hFFFF);
        chk("top_Tb", Tb, 16'h0000);
        chk("top_sat_pre", sat_hi, 0);
        vote(1, 0, 4);
        chk("sat_code", code, 16);
        chk("sat_hi_set", sat_hi, 1);
        vote(1, 0, 4);
        vote(0, 0, 3);
        chk("sat_hi_sticky", sat_hi, 1);
        chk("sat_code_held", code, 16);
        en = 1'b0;
        tick();
        chk("idle_sat_held", sat_hi, 1);
        chk("idle_code_held", code, 16);
        en = 1'b1;
        tick();
        chk("sat_hi_cleared", sat_hi, 0);

        // Saturation low.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        vote(0, 0, 1);
        vote(0, 1, 4);
        chk("sat_lo_code", code, 0);
        chk("sat_lo_set", {sat_hi, sat_lo}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
